// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//
// Shared constants, types and helpers for the programmable clock divider.
//
//   MIN_DIV     smallest effective divisor; written 0 or 1 behave as this
//   DIV_W       default divisor/counter width
//   div_t       divisor type at the default width
//   half_up()   ceil(n/2), the number of high cycles in one period
//   chan_idx_w() width of a channel index, never less than 1
//
// Optional feature macro used by the files that import this package:
//   CLK_DIV_PROG_SYNC_EN
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int MIN_DIV = 2;
    localparam int DIV_W   = 26;

    typedef logic [DIV_W-1:0] div_t;

    // ceil(n/2) without a divider: shift plus the dropped LSB.
    function automatic logic [63:0] half_up(input logic [63:0] n);
        return (n >> 1) + {63'd0, n[0]};
    endfunction

    // A single-channel divider still gets a 1-bit index port.
    function automatic int chan_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
//
// One channel of the programmable divider: period counter, active/shadow
// divisor pair with a pending flag, and the registered divided-clock and
// tick outputs.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   en      in   run enable; low holds the channel idle with outputs at 0
//   wr_en   in   write strobe, already decoded for this channel
//   wr_div  in   W-bit divisor to capture into the shadow register
//   sync    in   (only with CLK_DIV_PROG_SYNC_EN) restart the period now
//   pend    out  shadow divisor written but not yet active
//   clk_d   out  divided clock, high ceil(Ne/2) / low floor(Ne/2) cycles
//   tick    out  one-cycle strobe coinciding with each clk_d rising edge
//
// Optional feature macro: CLK_DIV_PROG_SYNC_EN adds the sync input.
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          W           = DIV_W,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         wr_en,
    input  logic [W-1:0] wr_div,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic         sync,
`endif
    output logic         pend,
    output logic         clk_d,
    output logic         tick
);

    localparam logic [W-1:0] RESET_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_N     = W'(MIN_DIV);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] act_reg;
    logic [W-1:0] shd_reg;
    logic         pend_reg;
    logic         clk_d_reg;
    logic         tick_reg;

    logic [W-1:0] ne;         // effective divisor of the running period
    logic [W-1:0] half;       // high-phase length, ceil(ne/2)
    logic         wrap;       // this edge closes the current period
    logic [W-1:0] cnt_next;
    logic         apply;      // move shadow into active on this edge

    always_comb begin
        ne       = (act_reg < MIN_N) ? MIN_N : act_reg;
        half     = W'(half_up(64'(ne)));
        wrap     = (cnt_reg == (ne - W'(1)));
        cnt_next = wrap ? '0 : (cnt_reg + W'(1));
        // An idle channel has no period to protect, so a pending divisor is
        // taken immediately; a running one waits for its period boundary.
        apply    = pend_reg && (!en || wrap);
`ifdef CLK_DIV_PROG_SYNC_EN
        // A sync restart is also a period boundary.
        if (en && sync && pend_reg) begin
            apply = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            act_reg   <= RESET_DIV;
            shd_reg   <= RESET_DIV;
            pend_reg  <= 1'b0;
            clk_d_reg <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            // Divisor update. The apply reads shd_reg before this edge's
            // write lands, so a coincident write stays pending for the
            // following boundary.
            if (apply) begin
                act_reg  <= shd_reg;
                pend_reg <= 1'b0;
            end
            if (wr_en) begin
                shd_reg  <= wr_div;
                pend_reg <= 1'b1;
            end

            // Counter and outputs.
            if (!en) begin
                cnt_reg   <= '0;
                clk_d_reg <= 1'b0;
                tick_reg  <= 1'b0;
`ifdef CLK_DIV_PROG_SYNC_EN
            end else if (sync) begin
                cnt_reg   <= '0;
                clk_d_reg <= 1'b1;
                tick_reg  <= 1'b1;
`endif
            end else begin
                cnt_reg   <= cnt_next;
                // clk_d follows the count it is about to hold, so the rise
                // lands on the same cycle as tick.
                clk_d_reg <= (cnt_next < half);
                tick_reg  <= wrap;
            end
        end
    end

    assign pend  = pend_reg;
    assign clk_d = clk_d_reg;
    assign tick  = tick_reg;

endmodule

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//
// Multi-channel programmable clock divider. Each of CH channels divides clk
// by its own runtime divisor N (period in clk cycles, even or odd) and
// produces a near-50% divided clock plus a one-cycle tick per period.
// New divisors go through a shared write port into a per-channel shadow
// register and take effect at the next period boundary.
//
// Parameters:
//   CH           number of channels (>= 1)
//   W            divisor/counter width (>= 2)
//   DEFAULT_DIV  divisor loaded into every channel at reset
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   en      in   [CH] per-channel run enable
//   wr_en   in   divisor write strobe
//   wr_ch   in   target channel; values >= CH are ignored
//   wr_div  in   [W] new divisor
//   sync    in   (only with CLK_DIV_PROG_SYNC_EN) phase-align enabled channels
//   pend    out  [CH] written divisor not yet applied
//   clk_d   out  [CH] divided clocks, registered
//   tick    out  [CH] period strobes, registered
//
// Optional feature macro: CLK_DIV_PROG_SYNC_EN adds the sync input.
// -----------------------------------------------------------------------------
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int          CH          = 4,
    parameter int          W           = $bits(div_t),
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH-1:0]                en,
    input  logic                         wr_en,
    input  logic [chan_idx_w(CH)-1:0]    wr_ch,
    input  logic [W-1:0]                 wr_div,
`ifdef CLK_DIV_PROG_SYNC_EN
    input  logic                         sync,
`endif
    output logic [CH-1:0]                pend,
    output logic [CH-1:0]                clk_d,
    output logic [CH-1:0]                tick
);

    // Per-channel write strobe. An index at or above CH matches no channel,
    // so such a write changes nothing.
    logic [CH-1:0] wr_hit;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_dec
            assign wr_hit[gi] = wr_en && (32'(wr_ch) == 32'(gi));
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            clk_div_chan #(
                .W           (W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (en[gi]),
                .wr_en  (wr_hit[gi]),
                .wr_div (wr_div),
`ifdef CLK_DIV_PROG_SYNC_EN
                .sync   (sync),
`endif
                .pend   (pend[gi]),
                .clk_d  (clk_d[gi]),
                .tick   (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
//
// Self-checking bench for clk_div_prog (CH=3, W=8, DEFAULT_DIV=4). The
// driver issues one set of inputs per clock, advances a period-level
// reference model and queues the outputs expected after that edge; a
// monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int DEF = 4;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [W-1:0]  wr_div;
    logic          sync_i;
    logic [CH-1:0] pend;
    logic [CH-1:0] clk_d;
    logic [CH-1:0] tick;

    always #5 clk = ~clk;

    clk_div_prog #(
        .CH          (CH),
        .W           (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
`ifdef CLK_DIV_PROG_SYNC_EN
        .sync   (sync_i),
`endif
        .pend   (pend),
        .clk_d  (clk_d),
        .tick   (tick)
    );

    typedef struct packed {
        logic [CH-1:0] pend;
        logic [CH-1:0] clk_d;
        logic [CH-1:0] tick;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model in period terms: which position of the current output
    // period each channel shows, and the divisor of that period.
    int m_act  [CH];
    int m_shd  [CH];
    int m_pos  [CH];
    int m_cur  [CH];
    bit m_pend [CH];
    bit m_run  [CH];

    function automatic int eff(input int n);
        return (n < 2) ? 2 : n;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_act[c]  = DEF;
            m_shd[c]  = DEF;
            m_pos[c]  = 0;
            m_cur[c]  = DEF;
            m_pend[c] = 1'b0;
            m_run[c]  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [CH-1:0] e, input logic we,
                              input int wc, input int wd, input logic sy,
                              output obs_t o);
        o = '0;
        for (int c = 0; c < CH; c++) begin
            if (!e[c]) begin
                if (m_pend[c]) begin
                    m_act[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
                m_run[c] = 1'b0;
            end else if (sy) begin
                if (m_pend[c]) begin
                    m_act[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
                m_run[c] = 1'b1;
                m_pos[c] = 0;
                m_cur[c] = eff(m_act[c]);
            end else if (!m_run[c]) begin
                // Fresh start: first visible cycle is the second of the period.
                m_run[c] = 1'b1;
                m_cur[c] = eff(m_act[c]);
                m_pos[c] = 1;
            end else begin
                m_pos[c]++;
                if (m_pos[c] == m_cur[c]) begin
                    m_pos[c] = 0;
                    if (m_pend[c]) begin
                        m_act[c]  = m_shd[c];
                        m_pend[c] = 1'b0;
                    end
                    m_cur[c] = eff(m_act[c]);
                end
            end
            if (m_run[c]) begin
                o.clk_d[c] = (m_pos[c] < (m_cur[c] + 1) / 2);
                o.tick[c]  = (m_pos[c] == 0);
            end
            if (we && wc == c) begin
                m_shd[c]  = wd;
                m_pend[c] = 1'b1;
            end
            o.pend[c] = m_pend[c];
        end
    endtask

    // Drive one cycle of inputs, model the edge that samples them, queue the
    // expected outputs, then move off the edge.
    task automatic step(input logic [CH-1:0] e, input logic we, input int wc,
                        input int wd, input logic sy);
        obs_t o;
        en     = e;
        wr_en  = we;
        wr_ch  = CW'(wc);
        wr_div = W'(wd);
        sync_i = sy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            o = '0;
        end else begin
            model_edge(e, we, wc, wd, sy, o);
        end
        exp_q.push_back(o);
        #1;
    endtask

    task automatic idle(input logic [CH-1:0] e, input int n);
        for (int i = 0; i < n; i++) step(e, 1'b0, 0, 0, 1'b0);
    endtask

    // Monitor / scoreboard.
    initial begin
        obs_t want;
        obs_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {pend, clk_d, tick};
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got pend=%b clk_d=%b tick=%b required pend=%b clk_d=%b tick=%b",
                             $time, got.pend, got.clk_d, got.tick,
                             want.pend, want.clk_d, want.tick);
                end
                $display("t=%0t en=%b pend=%b clk_d=%b tick=%b", $time, en, pend, clk_d, tick);
            end
        end
    end

    // Driver.
    initial begin
        logic [CH-1:0] e_cur;
        logic          sy;
        int            guard;

        rst_n  = 1'b0;
        en     = '0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        sync_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle('0, 3);                 // reset state
        rst_n = 1'b1;

        idle(3'b001, 12);            // ch0 at default N=4

        e_cur = 3'b111;
        idle(e_cur, 3);
        step(e_cur, 1'b1, 1, 5, 1'b0);   // ch1 -> 5 while running
        idle(e_cur, 14);

        step(e_cur, 1'b1, 0, 0, 1'b0);   // 0 behaves as 2
        idle(e_cur, 8);
        step(e_cur, 1'b1, 0, 1, 1'b0);   // 1 behaves as 2
        idle(e_cur, 8);
        step(e_cur, 1'b1, 3, 7, 1'b0);   // out-of-range channel
        idle(e_cur, 3);

        // Write to ch2 on the edge that applies its previous write.
        step(e_cur, 1'b1, 2, 7, 1'b0);
        guard = 0;
        while (!(m_pend[2] && m_run[2] && (m_pos[2] + 1 == m_cur[2])) && guard < 50) begin
            step(e_cur, 1'b0, 0, 0, 1'b0);
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL ch2_collision_setup waited=%0d cycles, required < 50", guard);
        end
        step(e_cur, 1'b1, 2, 3, 1'b0);
        idle(e_cur, 20);

        // Drop ch0 mid-period, then restart it.
        idle(e_cur, 2);
        idle(3'b110, 3);
        idle(e_cur, 10);

        // Asynchronous reset between edges with a pending write outstanding.
        step(e_cur, 1'b1, 1, 6, 1'b0);
        exp_q.delete();
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pend, clk_d, tick} !== '0) begin
            n_bad++;
            $display("FAIL async_rst got pend=%b clk_d=%b tick=%b required all 0",
                     pend, clk_d, tick);
        end
        @(posedge clk);
        #1;
        idle(e_cur, 2);
        rst_n = 1'b1;
        idle(e_cur, 10);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) e_cur[$urandom_range(0, CH-1)] ^= 1'b1;
            sy = 1'b0;
`ifdef CLK_DIV_PROG_SYNC_EN
            sy = ($urandom_range(0, 39) == 0);
`endif
            if ($urandom_range(0, 5) == 0)
                step(e_cur, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), sy);
            else
                step(e_cur, 1'b0, 0, 0, sy);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
